// File: rtl/wbs_sram16.sv
// Wishbone-style slave in front of a halfword SRAM with a programmable number of wait states.
// Every access returns the old contents of the addressed word; a write commits on the edge that ends ACK.
module wbs_sram16 #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [63:0] wbsadr_i,
  input  logic [15:0] wbsdat_i,
  input  logic        wbswe_i,
  input  logic        wbsstb_i,
  output logic        wbsack_o,
  output logic [15:0] wbsdat_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, adr_idx, rd_idx;
  logic [15:0]           wdat_q;
  logic                  we_q;
  logic [3:0]            cnt_q;
  logic                  capture, enter_ack;
  logic                  unused_adr;
  logic [15:0]           mem [0:(2**DEPTH_LOG2)-1];

  // Byte address selects a halfword; bit 0 and the upper bits simply alias.
  assign adr_idx    = wbsadr_i[DEPTH_LOG2:1];
  assign unused_adr = ^{wbsadr_i[63:DEPTH_LOG2+1], wbsadr_i[0]};
  assign capture    = (state_q == S_IDLE) && wbsstb_i;
  assign enter_ack  = (state_d == S_ACK) && (state_q != S_ACK);
  assign rd_idx     = (state_q == S_IDLE) ? adr_idx : idx_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (wbsstb_i) state_d = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wbsack_o = (state_q == S_ACK);
    busy_o   = (state_q != S_IDLE);
  end

  // Read data is sampled on the edge entering ACK, so it always precedes this request's write.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idx_q    <= '0;
      wdat_q   <= 16'h0000;
      we_q     <= 1'b0;
      cnt_q    <= 4'd0;
      wbsdat_o <= 16'h0000;
    end else begin
      if (capture) begin
        idx_q  <= adr_idx;
        wdat_q <= wbsdat_i;
        we_q   <= wbswe_i;
        cnt_q  <= CNT_LOAD;
      end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_ack) wbsdat_o <= mem[rd_idx];
    end
  end

  // The array has no reset; an aborted request never reaches ACK and so never writes.
  always_ff @(posedge clk_i) begin
    if ((state_q == S_ACK) && we_q) mem[idx_q] <= wdat_q;
  end

endmodule

// File: tb/tb_wbs_sram16.sv
// Self-checking bench for wbs_sram16: three instances (1, 0 and 15 wait states) driven by directed steps,
// with a scoreboard of expected acknowledge cycle and read data checked whenever an ack appears.
module tb_wbs_sram16;

  localparam int WS0 = 1;
  localparam int WS1 = 0;
  localparam int WS2 = 15;

  typedef struct {
    int          inst;
    int          cyc;
    logic [15:0] dat;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        stb   [3];
  logic        we    [3];
  logic        ack   [3];
  logic        busy  [3];
  logic [63:0] adr   [3];
  logic [15:0] dati  [3];
  logic [15:0] dato  [3];

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb [$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  wbs_sram16 #(.DEPTH_LOG2(10), .WAIT_STATES(WS0)) u0 (
    .clk_i(clk), .reset_ni(rst_n[0]), .wbsadr_i(adr[0]), .wbsdat_i(dati[0]), .wbswe_i(we[0]),
    .wbsstb_i(stb[0]), .wbsack_o(ack[0]), .wbsdat_o(dato[0]), .busy_o(busy[0]));
  wbs_sram16 #(.DEPTH_LOG2(10), .WAIT_STATES(WS1)) u1 (
    .clk_i(clk), .reset_ni(rst_n[1]), .wbsadr_i(adr[1]), .wbsdat_i(dati[1]), .wbswe_i(we[1]),
    .wbsstb_i(stb[1]), .wbsack_o(ack[1]), .wbsdat_o(dato[1]), .busy_o(busy[1]));
  wbs_sram16 #(.DEPTH_LOG2(10), .WAIT_STATES(WS2)) u2 (
    .clk_i(clk), .reset_ni(rst_n[2]), .wbsadr_i(adr[2]), .wbsdat_i(dati[2]), .wbswe_i(we[2]),
    .wbsstb_i(stb[2]), .wbsack_o(ack[2]), .wbsdat_o(dato[2]), .busy_o(busy[2]));

  function automatic int wsOf(input int g);
    return (g == 0) ? WS0 : ((g == 1) ? WS1 : WS2);
  endfunction

  // Every ack must match the oldest outstanding expectation in instance, cycle and (optionally) data.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ack[g] === 1'b1) begin
        compared++;
        assert (sb.size() != 0) else begin
          mismatched++;
          $error("[TB] FAIL unexpected_ack inst=%0d cyc=%0d observed=1 expected=0", g, cyc);
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          compared++;
          assert (g == mon_e.inst && cyc == mon_e.cyc) else begin
            mismatched++;
            $error("[TB] FAIL ack_timing observed=inst%0d@%0d expected=inst%0d@%0d", g, cyc, mon_e.inst, mon_e.cyc);
          end
          if (mon_e.chk) begin
            compared++;
            assert (dato[g] === mon_e.dat) else begin
              mismatched++;
              $error("[TB] FAIL ack_data inst=%0d observed=%h expected=%h", g, dato[g], mon_e.dat);
            end
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int g, input logic w, input logic [63:0] a, input logic [15:0] d,
                               input logic [15:0] ed, input bit chk);
    exp_t e;
    @(negedge clk);
    adr[g] = a; dati[g] = d; we[g] = w; stb[g] = 1'b1;
    e.inst = g; e.cyc = cyc + 1 + wsOf(g); e.dat = ed; e.chk = chk;
    sb.push_back(e);
    @(negedge clk);
    stb[g] = 1'b0;
    checkOutput("busy_after_capture", 16'(busy[g]), 16'h0001);
  endtask

  task automatic waitIdle(input int g);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("[TB] FAIL ack_timeout inst=%0d observed=%0d pending expected=0", g, sb.size());
      sb.delete();
    end
    @(negedge clk);
    checkOutput("busy_idle", 16'(busy[g]), 16'h0000);
  endtask

  initial begin
    exp_t e;
    int   k;
    for (int g = 0; g < 3; g++) begin
      rst_n[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0; adr[g] = '0; dati[g] = '0;
    end
    #3;
    for (int g = 0; g < 3; g++) begin
      checkOutput("reset_ack", 16'(ack[g]), 16'h0000);
      checkOutput("reset_busy", 16'(busy[g]), 16'h0000);
      checkOutput("reset_dat", dato[g], 16'h0000);
    end
    @(negedge clk);
    for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;

    // One wait state: aliasing, bit 0 ignored, read-before-write.
    applyStimulus(0, 1'b1, 64'h1122334455667788, 16'hDEAD, 16'h0000, 1'b0);
    waitIdle(0);
    applyStimulus(0, 1'b0, 64'h0000000000000788, 16'h0000, 16'hDEAD, 1'b1);
    waitIdle(0);
    applyStimulus(0, 1'b0, 64'h0000000000000789, 16'h0000, 16'hDEAD, 1'b1);
    waitIdle(0);
    applyStimulus(0, 1'b1, 64'h0000000000000788, 16'hBEEF, 16'hDEAD, 1'b1);
    waitIdle(0);
    applyStimulus(0, 1'b0, 64'h0000000000000788, 16'h0000, 16'hBEEF, 1'b1);
    waitIdle(0);
    checkOutput("dat_hold", dato[0], 16'hBEEF);

    // Strobe held for ten clocks: captures every third edge.
    @(negedge clk);
    adr[0] = 64'h788; we[0] = 1'b0; stb[0] = 1'b1;
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      e.inst = 0; e.cyc = k + 2 + 3 * i; e.dat = 16'hBEEF; e.chk = 1'b1;
      sb.push_back(e);
    end
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      checkOutput("held_busy", 16'(busy[0]), (j % 3 != 0) ? 16'h0001 : 16'h0000);
    end
    stb[0] = 1'b0;
    waitIdle(0);

    // Zero wait states: ack in the clock right after capture, strobe during ACK dropped.
    applyStimulus(1, 1'b1, 64'h20, 16'hABCD, 16'h0000, 1'b0);
    waitIdle(1);
    applyStimulus(1, 1'b0, 64'h21, 16'h0000, 16'hABCD, 1'b1);
    waitIdle(1);
    @(negedge clk);
    adr[1] = 64'h20; we[1] = 1'b0; stb[1] = 1'b1;
    e.inst = 1; e.cyc = cyc + 1; e.dat = 16'hABCD; e.chk = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    checkOutput("ws0_busy_ack", 16'(busy[1]), 16'h0001);
    @(negedge clk);
    stb[1] = 1'b0;
    checkOutput("ws0_busy_dropped", 16'(busy[1]), 16'h0000);
    waitIdle(1);

    // Fifteen wait states: long latency, strobe during WAIT ignored, reset aborts a write.
    applyStimulus(2, 1'b1, 64'h10, 16'h5555, 16'h0000, 1'b0);
    waitIdle(2);
    applyStimulus(2, 1'b0, 64'h10, 16'h0000, 16'h5555, 1'b1);
    repeat (3) @(negedge clk);
    adr[2] = 64'h30; we[2] = 1'b1; dati[2] = 16'h7777; stb[2] = 1'b1;
    @(negedge clk);
    stb[2] = 1'b0;
    waitIdle(2);
    checkOutput("ws15_dat_hold", dato[2], 16'h5555);
    @(negedge clk);
    adr[2] = 64'h10; we[2] = 1'b1; dati[2] = 16'h1234; stb[2] = 1'b1;
    @(negedge clk);
    stb[2] = 1'b0;
    checkOutput("abort_busy_before", 16'(busy[2]), 16'h0001);
    #2 rst_n[2] = 1'b0;
    #1;
    checkOutput("abort_ack", 16'(ack[2]), 16'h0000);
    checkOutput("abort_busy", 16'(busy[2]), 16'h0000);
    checkOutput("abort_dat", dato[2], 16'h0000);
    @(negedge clk);
    rst_n[2] = 1'b1;
    applyStimulus(2, 1'b0, 64'h10, 16'h0000, 16'h5555, 1'b1);
    waitIdle(2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
